countdown_timer: RTL and testbench

Parametrised game countdown timer for the reaction-game top level. It divides the system clock into game ticks, loads a programmable duration and counts down once per tick, with pause/resume and clear. It holds at zero on expiry instead of wrapping, flashes an LED bank while expired, and presents the remaining time both in binary and as two BCD digits for the seven-segment decoders.

---
 rtl/countdown_timer_pkg.sv | 21 ++
 rtl/countdown_timer_if.sv | 30 +++
 rtl/countdown_timer_tick_prescaler.sv | 28 ++
 rtl/countdown_timer.sv | 110 +++++++++++
 tb/tb_countdown_timer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the game countdown timer.
// Holds the FSM state encoding and the binary-to-two-digit BCD conversion.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  localparam int unsigned BCD_MAX = 99;

  // Returns {tens, ones}; anything past two digits saturates to 99.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    int unsigned v;
    v = (value > BCD_MAX) ? BCD_MAX : value;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the game controller and the countdown timer.
// The master drives start/duration/pause/clear; the timer (slave) drives the display side.
interface countdown_timer_if #(
  parameter int W    = 5,
  parameter int NLED = 10
);

  logic            start;
  logic [W-1:0]    duration_in;
  logic            pause;
  logic            clear;
  logic [W-1:0]    time_now;
  logic [3:0]      bcd_tens;
  logic [3:0]      bcd_ones;
  logic            running;
  logic            expired;
  logic            done;
  logic [NLED-1:0] led;

  modport master (
    output start, duration_in, pause, clear,
    input  time_now, bcd_tens, bcd_ones, running, expired, done, led
  );

  modport slave (
    input  start, duration_in, pause, clear,
    output time_now, bcd_tens, bcd_ones, running, expired, done, led
  );

endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides the system clock into one-cycle game ticks, every DIV cycles while enabled.
// The count holds when disabled so a paused countdown resumes without losing a tick.
module tick_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || zero) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Game countdown timer: loads a duration, counts down once per tick, holds at zero
// on expiry and flashes an LED bank until restarted or cleared.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int DIV      = 50_000_000,
  parameter int W        = 5,
  parameter int DURATION = 31,
  parameter int NLED     = 10
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  localparam logic [W-1:0] DUR_INIT = W'(DURATION);

  timer_state_t    state, state_next;
  logic [W-1:0]    time_q, time_next;
  logic [NLED-1:0] led_q, led_next;
  logic            done_q, done_next;
  logic            tick;
  logic            presc_en;
  logic            presc_zero;
  logic [7:0]      bcd;

  assign presc_en   = (state == RUN) || (state == EXPIRED);
  assign presc_zero = bus.clear || bus.start;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .zero (presc_zero),
    .tick (tick)
  );

  // clear outranks start, which outranks pause; start swallows a coincident tick.
  always_comb begin
    state_next = state;
    time_next  = time_q;
    led_next   = led_q;
    done_next  = 1'b0;
    if (bus.clear) begin
      state_next = IDLE;
      time_next  = DUR_INIT;
      led_next   = '0;
    end else if (bus.start) begin
      time_next  = bus.duration_in;
      led_next   = '0;
      state_next = bus.pause ? PAUSED : RUN;
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            if (time_q != '0) begin
              time_next = time_q - 1'b1;
            end else begin
              state_next = EXPIRED;
              done_next  = 1'b1;
              led_next   = '1;
            end
          end
          if (bus.pause && (state_next == RUN)) begin
            state_next = PAUSED;
          end
        end
        PAUSED: begin
          if (!bus.pause) begin
            state_next = RUN;
          end
        end
        EXPIRED: begin
          if (tick) begin
            led_next = ~led_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      time_q <= DUR_INIT;
      led_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      time_q <= time_next;
      led_q  <= led_next;
      done_q <= done_next;
    end
  end

  assign bcd = to_bcd(32'(time_q));

  assign bus.time_now = time_q;
  assign bus.bcd_tens = bcd[7:4];
  assign bus.bcd_ones = bcd[3:0];
  assign bus.running  = (state == RUN);
  assign bus.expired  = (state == EXPIRED);
  assign bus.done     = done_q;
  assign bus.led      = led_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer with DIV = 4, W = 5, NLED = 10.
// Inputs change on the falling edge; outputs are compared 1 time unit after each rising edge.
module tb_countdown_timer;

  typedef struct {
    logic       start;
    logic [4:0] dur;
    logic       pause;
    logic       clear;
    logic [4:0] t;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       done;
    logic       led_on;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_count = 0;
  int   check_count = 0;

  countdown_timer_if #(.W(5), .NLED(10)) bus ();

  countdown_timer #(
    .DIV      (4),
    .W        (5),
    .DURATION (31),
    .NLED     (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [4:0] d, input logic p, input logic c,
                              input logic [4:0] t, input logic [3:0] tens, input logic [3:0] ones,
                              input logic run, input logic exp, input logic dn, input logic led);
    vec_t v;
    v.start = s; v.dur = d; v.pause = p; v.clear = c;
    v.t = t; v.tens = tens; v.ones = ones;
    v.running = run; v.expired = exp; v.done = dn; v.led_on = led;
    return v;
  endfunction

  // Drives one set of inputs across exactly one rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.start       = v.start;
    bus.duration_in = v.dur;
    bus.pause       = v.pause;
    bus.clear       = v.clear;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [25:0] act;
    logic [25:0] req;
    act = {bus.time_now, bus.bcd_tens, bus.bcd_ones, bus.running, bus.expired, bus.done, bus.led};
    req = {v.t, v.tens, v.ones, v.running, v.expired, v.done, {10{v.led_on}}};
    check_count++;
    if (act === req) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got time=%0d tens=%0d ones=%0d run=%b exp=%b done=%b led=%b, want time=%0d tens=%0d ones=%0d run=%b exp=%b done=%b led=%b",
               name, bus.time_now, bus.bcd_tens, bus.bcd_ones, bus.running, bus.expired, bus.done, bus.led,
               v.t, v.tens, v.ones, v.running, v.expired, v.done, {10{v.led_on}});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checked", pass_count, check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[26];
    vec_t idle_v;

    bus.start = 1'b0; bus.duration_in = '0; bus.pause = 1'b0; bus.clear = 1'b0;

    // start 3: 3,2,1,0 each for one tick, expire on the 4th tick, LEDs toggle every 4 cycles, then clear
    vecs[0] = mk(1, 3, 0, 0, 3, 0, 3, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++)   vecs[i] = mk(0, 0, 0, 0, 3, 0, 3, 1, 0, 0, 0);
    for (int i = 4; i <= 7; i++)   vecs[i] = mk(0, 0, 0, 0, 2, 0, 2, 1, 0, 0, 0);
    for (int i = 8; i <= 11; i++)  vecs[i] = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 12; i <= 15; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    for (int i = 17; i <= 19; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 20; i <= 23; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vecs[25] = mk(0, 0, 0, 1, 31, 3, 1, 0, 0, 0, 0);

    idle_v = mk(0, 0, 0, 0, 31, 3, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", idle_v);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(idle_v);
    checkOutput("idle20", idle_v);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("expire_seq[%0d]", i), vecs[i]);
    end

    // start 5, pause sampled on edges 2..11: first decrement lands on edge 14
    applyStimulus(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("pause_load", mk(0, 0, 0, 0, 5, 0, 5, 1, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int e = 2; e <= 11; e++) begin
      applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (e == 2 || e == 11) checkOutput($sformatf("paused_e%0d", e), mk(0, 0, 0, 0, 5, 0, 5, 0, 0, 0, 0));
    end
    for (int e = 12; e <= 18; e++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (e == 12 || e == 13) checkOutput($sformatf("resume_e%0d", e), mk(0, 0, 0, 0, 5, 0, 5, 1, 0, 0, 0));
      if (e == 14 || e == 17) checkOutput($sformatf("resume_e%0d", e), mk(0, 0, 0, 0, 4, 0, 4, 1, 0, 0, 0));
      if (e == 18)            checkOutput("resume_e18", mk(0, 0, 0, 0, 3, 0, 3, 1, 0, 0, 0));
    end

    // start 9, then restart with 12 on the very edge a tick would have taken 7 to 6
    applyStimulus(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (e == 8 || e == 11) checkOutput($sformatf("restart_pre_e%0d", e), mk(0, 0, 0, 0, 7, 0, 7, 1, 0, 0, 0));
    end
    applyStimulus(mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("restart_load", mk(0, 0, 0, 0, 12, 1, 2, 1, 0, 0, 0));
    for (int e = 13; e <= 16; e++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (e == 15) checkOutput("restart_hold", mk(0, 0, 0, 0, 12, 1, 2, 1, 0, 0, 0));
      if (e == 16) checkOutput("restart_dec", mk(0, 0, 0, 0, 11, 1, 1, 1, 0, 0, 0));
    end

    // start and pause together: load 9 into PAUSED, then release
    applyStimulus(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("startpause_load", mk(0, 0, 0, 0, 9, 0, 9, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("startpause_hold", mk(0, 0, 0, 0, 9, 0, 9, 0, 0, 0, 0));
    for (int r = 0; r <= 4; r++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (r == 0 || r == 3) checkOutput($sformatf("release_r%0d", r), mk(0, 0, 0, 0, 9, 0, 9, 1, 0, 0, 0));
      if (r == 4)           checkOutput("release_r4", mk(0, 0, 0, 0, 8, 0, 8, 1, 0, 0, 0));
    end

    // synchronous reset mid-countdown
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_midrun", idle_v);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
